// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, illegal-opcode check and FSM state type for
// the ALU operation sequencer.
package alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ZERO  = 4'b0000;
    localparam logic [OP_W-1:0] OP_CMP   = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b1011;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b1100;
    localparam logic [OP_W-1:0] OP_ILL_0 = 4'b1101;
    localparam logic [OP_W-1:0] OP_ILL_1 = 4'b1110;
    localparam logic [OP_W-1:0] OP_ONES  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } seq_state_e;

    // The two encodings the ALU leaves undefined.
    function automatic logic is_illegal_op(input logic [OP_W-1:0] sel);
        return (sel == OP_ILL_0) || (sel == OP_ILL_1);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one request at a time to an external combinational ALU, holds the
// registered operands for SETTLE_CYCLES clocks, captures X and returns it
// over a valid/ready response handshake.
// Optional feature: define ALU_SEQ_CHAIN_EN to let a request use the last
// good result as operand A (req_chain=1).
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W        = 6,
    parameter int unsigned SEL_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_chain,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_x,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_x,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_x_q, resp_x_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] operand_a;
    logic              req_illegal;

`ifdef ALU_SEQ_CHAIN_EN
    logic [DATA_W-1:0] last_result_q, last_result_d;

    // Operand A source: previous good result when chaining.
    always_comb begin
        operand_a = req_chain ? last_result_q : req_a;
    end
`else
    logic unused_chain;
    assign unused_chain = req_chain;

    // Operand A source: always the request operand.
    always_comb begin
        operand_a = req_a;
    end
`endif

    assign req_illegal = is_illegal_op(OP_W'(req_sel));
    assign req_ready   = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign alu_sel     = alu_sel_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign resp_valid  = resp_valid_q;
    assign resp_x      = resp_x_q;
    assign resp_err    = resp_err_q;

    // Next-state logic: accept, settle countdown, capture, response hold.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_x_d     = resp_x_q;
        resp_err_d   = resp_err_q;
`ifdef ALU_SEQ_CHAIN_EN
        last_result_d = last_result_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_illegal) begin
                        alu_sel_d = SEL_W'(OP_ZERO);
                        alu_a_d   = '0;
                        alu_b_d   = '0;
                        err_d     = 1'b1;
                    end else begin
                        alu_sel_d = req_sel;
                        alu_a_d   = operand_a;
                        alu_b_d   = req_b;
                        err_d     = 1'b0;
                    end
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    resp_x_d     = err_q ? '0 : alu_x;
                    resp_err_d   = err_q;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
`ifdef ALU_SEQ_CHAIN_EN
                    if (!resp_err_q) begin
                        last_result_d = resp_x_q;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_sel_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_x_q     <= '0;
            resp_err_q   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            last_result_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_x_q     <= resp_x_d;
            resp_err_q   <= resp_err_d;
`ifdef ALU_SEQ_CHAIN_EN
            last_result_q <= last_result_d;
`endif
        end
    end

endmodule
